led_frame_scheduler: RTL and testbench

- Sits between the linear visualizer and the LED serial driver; owns the driver's start/done handshake.
- Accepts complete frames (per-bin colours plus per-bin LED counts) over a valid/ready handshake and sanitizes the counts so their total never exceeds LEDS.
- Enforces a minimum frame period and holds the frame stable while the driver latches it.
- Refreshes the strip with the last frame when input stalls; blanks the strip after a bounded number of repeats.

---
 rtl/led_frame_scheduler.sv | 161 ++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scheduler.sv
// Frame scheduler between the linear visualizer and the LED serial driver.
// Accepts frames over valid/ready, clips per-bin LED counts so their total
// never exceeds LEDS, paces driver starts to a minimum period, re-sends the
// active frame when input stalls and blanks it after too many repeats.
module led_frame_scheduler #(
  parameter int LEDS           = 50,
  parameter int BIN_QTY        = 12,
  parameter int MIN_PERIOD     = 125000,
  parameter int REFRESH_CYCLES = 1250000,
  parameter int MAX_REPEATS    = 8,
  parameter int CW             = $clog2(LEDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIN_QTY-1:0][23:0]      in_rgb,
  input  logic [BIN_QTY-1:0][CW-1:0]    in_counts,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BIN_QTY-1:0][23:0]      drv_rgb,
  output logic [BIN_QTY-1:0][CW-1:0]    drv_counts,
  output logic                          drv_start,
  input  logic                          drv_done,
  output logic                          busy,
  output logic                          clipped,
  output logic [15:0]                   frames_sent
);

  localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam int PW = $clog2(MIN_PERIOD + 1);
  localparam int IW = $clog2(REFRESH_CYCLES + 1);
  localparam int RW = $clog2(MAX_REPEATS + 1);

  localparam logic [PW-1:0] PERIOD_FULL  = PW'(MIN_PERIOD);
  localparam logic [IW-1:0] IDLE_LAST    = IW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] REPEAT_LIMIT = RW'(MAX_REPEATS);
  localparam logic [CW:0]   LEDS_SUM     = (CW+1)'(LEDS);
  localparam logic [BW-1:0] LAST_BIN     = BW'(BIN_QTY - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_KICK  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  logic [2:0]                   state;
  logic [PW-1:0]                period_timer;
  logic [IW-1:0]                idle_timer;
  logic [RW-1:0]                repeat_cnt;
  logic [BIN_QTY-1:0][23:0]     stage_rgb;
  logic [BIN_QTY-1:0][CW-1:0]   stage_counts;
  logic [BW-1:0]                bin_idx;
  logic [CW:0]                  sum;

  logic [CW-1:0]                cur_count;
  logic [CW+1:0]                total;
  logic                         over;
  logic [CW-1:0]                next_count;
  logic [CW:0]                  next_sum;
  logic                         kick_go;

  assign drv_start = (state == S_KICK);
  assign busy      = (state != S_IDLE);
  assign kick_go   = (state == S_ARM) && (period_timer == PERIOD_FULL) && drv_done;

  // Clip the current bin against the LEDs still available.
  always_comb begin
    cur_count  = stage_counts[bin_idx];
    total      = {1'b0, sum} + {2'b00, cur_count};
    over       = total > {1'b0, LEDS_SUM};
    next_count = over ? CW'(LEDS_SUM - sum) : cur_count;
    next_sum   = over ? LEDS_SUM : total[CW:0];
  end

  // Period timer: restarts on each start request, saturates at MIN_PERIOD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      period_timer <= PERIOD_FULL;
    end else if (kick_go) begin
      period_timer <= '0;
    end else if (period_timer != PERIOD_FULL) begin
      period_timer <= period_timer + PW'(1);
    end
  end

  // Frame FSM: accept, sanitize, pace, hand to driver, refresh/blank on idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      idle_timer   <= '0;
      repeat_cnt   <= '0;
      stage_rgb    <= '0;
      stage_counts <= '0;
      bin_idx      <= '0;
      sum          <= '0;
      clipped      <= 1'b0;
      frames_sent  <= '0;
      drv_rgb      <= '0;
      drv_counts   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            stage_rgb    <= in_rgb;
            stage_counts <= in_counts;
            bin_idx      <= '0;
            sum          <= '0;
            clipped      <= 1'b0;
            repeat_cnt   <= '0;
            idle_timer   <= '0;
            in_ready     <= 1'b0;
            state        <= S_CHECK;
          end else if (idle_timer == IDLE_LAST) begin
            idle_timer <= '0;
            if (repeat_cnt == REPEAT_LIMIT) begin
              drv_rgb <= '0;
            end else begin
              repeat_cnt <= repeat_cnt + RW'(1);
            end
            in_ready <= 1'b0;
            state    <= S_ARM;
          end else begin
            idle_timer <= idle_timer + IW'(1);
            in_ready   <= 1'b1;
          end
        end
        S_CHECK: begin
          stage_counts[bin_idx] <= next_count;
          sum                   <= next_sum;
          if (over) clipped <= 1'b1;
          bin_idx <= bin_idx + BW'(1);
          if (bin_idx == LAST_BIN) begin
            // Last bin's clipped value is not yet in staging; patch it in.
            drv_rgb                 <= stage_rgb;
            drv_counts              <= stage_counts;
            drv_counts[BIN_QTY-1]   <= next_count;
            state                   <= S_ARM;
          end
        end
        S_ARM: begin
          if (kick_go) state <= S_KICK;
        end
        S_KICK: begin
          if (!drv_done) state <= S_RUN;
        end
        S_RUN: begin
          if (drv_done) begin
            frames_sent <= frames_sent + 16'd1;
            in_ready    <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler with a behavioural driver
// model and a count-sanitizing reference model.
module tb_led_frame_scheduler;

  localparam int LEDS = 50;
  localparam int BQ   = 12;
  localparam int CW   = 6;
  localparam int MP   = 100;
  localparam int RC   = 1000;
  localparam int MR   = 3;

  typedef logic [BQ-1:0][23:0]   rgb_t;
  typedef logic [BQ-1:0][CW-1:0] cnt_t;

  logic        clk;
  logic        rst;
  rgb_t        in_rgb;
  cnt_t        in_counts;
  logic        in_valid;
  logic        in_ready;
  rgb_t        drv_rgb;
  cnt_t        drv_counts;
  logic        drv_start;
  logic        drv_done;
  logic        busy;
  logic        clipped;
  logic [15:0] frames_sent;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fs_exp      = 0;
  int drop_dly    = 5;
  int rise_dly    = 200;
  int done_rise_cyc = -1;

  int   st_cyc[$];
  rgb_t st_rgb[$];
  cnt_t st_cnt[$];

  led_frame_scheduler #(
    .LEDS(LEDS), .BIN_QTY(BQ), .MIN_PERIOD(MP),
    .REFRESH_CYCLES(RC), .MAX_REPEATS(MR)
  ) dut (
    .clk(clk), .rst(rst), .in_rgb(in_rgb), .in_counts(in_counts),
    .in_valid(in_valid), .in_ready(in_ready), .drv_rgb(drv_rgb),
    .drv_counts(drv_counts), .drv_start(drv_start), .drv_done(drv_done),
    .busy(busy), .clipped(clipped), .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each bin takes what it asks for, up to the LEDs left.
  function automatic cnt_t model_counts(input cnt_t c);
    int remaining;
    cnt_t o;
    remaining = LEDS;
    for (int i = 0; i < BQ; i++) begin
      int take;
      take = (int'(c[i]) < remaining) ? int'(c[i]) : remaining;
      o[i] = CW'(take);
      remaining -= take;
    end
    return o;
  endfunction

  function automatic bit model_clip(input cnt_t c);
    int tot;
    tot = 0;
    for (int i = 0; i < BQ; i++) tot += int'(c[i]);
    return tot > LEDS;
  endfunction

  function automatic rgb_t rand_rgb();
    rgb_t v;
    for (int i = 0; i < BQ; i++) v[i] = 24'($urandom());
    return v;
  endfunction

  // Driver model: busy a few cycles after start, done again much later.
  initial begin
    drv_done = 1'b1;
    forever begin
      @(negedge clk);
      if (drv_start) begin
        repeat (drop_dly) @(posedge clk);
        #1 drv_done = 1'b0;
        repeat (rise_dly) @(posedge clk);
        #1 drv_done = 1'b1;
        done_rise_cyc = cyc;
      end
    end
  end

  // Start monitor: logs each start, checks spacing and frame stability.
  initial begin
    int   last_start;
    logic prev_start;
    rgb_t snap_rgb;
    cnt_t snap_cnt;
    last_start = -1;
    prev_start = 1'b0;
    snap_rgb   = '0;
    snap_cnt   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_start = -1;
        prev_start = 1'b0;
      end else begin
        if (drv_start && !prev_start) begin
          if (last_start >= 0) begin
            vectors++;
            if (cyc - last_start < MP) begin
              miscompares++;
              $display("FAIL start_spacing: got %0d cycles, need >= %0d", cyc - last_start, MP);
            end
          end
          last_start = cyc;
          snap_rgb = drv_rgb;
          snap_cnt = drv_counts;
          st_cyc.push_back(cyc);
          st_rgb.push_back(drv_rgb);
          st_cnt.push_back(drv_counts);
        end else if (drv_start) begin
          vectors++;
          if (drv_rgb !== snap_rgb || drv_counts !== snap_cnt) begin
            miscompares++;
            $display("FAIL kick_freeze: got counts %h, need %h", drv_counts, snap_cnt);
          end
        end
        prev_start = drv_start;
      end
    end
  end

  task automatic clear_log();
    st_cyc.delete();
    st_rgb.delete();
    st_cnt.delete();
  endtask

  task automatic send_frame(input rgb_t r, input cnt_t c, output int acc);
    @(posedge clk);
    #1;
    in_rgb    = r;
    in_counts = c;
    in_valid  = 1'b1;
    acc       = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (acc < 0) begin
      miscompares++;
      $display("FAIL accept_timeout: got no accept, need accept within 2000 cycles");
    end
  endtask

  task automatic wait_start(input int budget, output int s, output rgb_t r, output cnt_t c);
    s = -1;
    r = '0;
    c = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st_cyc.size() > 0) begin
        s = st_cyc.pop_front();
        r = st_rgb.pop_front();
        c = st_cnt.pop_front();
        break;
      end
    end
    vectors++;
    if (s < 0) begin
      miscompares++;
      $display("FAIL start_timeout: got no drv_start, need one within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget, output int f);
    f = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        f = cyc;
        break;
      end
    end
    vectors++;
    if (f < 0) begin
      miscompares++;
      $display("FAIL idle_timeout: got busy, need idle within %0d cycles", budget);
    end
  endtask

  task automatic check_sent(input string name);
    vectors++;
    if (frames_sent !== 16'(fs_exp)) begin
      miscompares++;
      $display("FAIL %s frames_sent: got %0d, need %0d", name, frames_sent, fs_exp);
    end
  endtask

  task automatic run_frame(input string name, input cnt_t c, input bit chk_lat);
    rgb_t r, gr;
    cnt_t exp_c, gc;
    bit   exp_clip;
    int   acc, s, f;
    r        = rand_rgb();
    exp_c    = model_counts(c);
    exp_clip = model_clip(c);
    clear_log();
    send_frame(r, c, acc);
    wait_start(400, s, gr, gc);
    if (s >= 0) begin
      if (chk_lat) begin
        vectors++;
        if (s - acc != 13) begin
          miscompares++;
          $display("FAIL %s latency: got %0d, need 13", name, s - acc);
        end
      end
      vectors++;
      if (gc !== exp_c) begin
        miscompares++;
        $display("FAIL %s counts: got %h, need %h", name, gc, exp_c);
      end
      vectors++;
      if (gr !== r) begin
        miscompares++;
        $display("FAIL %s rgb: got %h, need %h", name, gr, r);
      end
      vectors++;
      if (clipped !== exp_clip) begin
        miscompares++;
        $display("FAIL %s clipped: got %b, need %b", name, clipped, exp_clip);
      end
    end
    wait_idle(500, f);
    fs_exp++;
    check_sent(name);
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_rgb   = '0;
    in_counts = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || drv_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b start=%b, need 0 0 0", in_ready, busy, drv_start);
    end
    vectors++;
    if (clipped !== 1'b0 || frames_sent !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_status: got clipped=%b sent=%0d, need 0 0", clipped, frames_sent);
    end
    vectors++;
    if (drv_rgb !== '0 || drv_counts !== '0) begin
      miscompares++;
      $display("FAIL reset_frame: got rgb=%h counts=%h, need 0", drv_rgb, drv_counts);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b, need 1", in_ready);
    end
    fs_exp = 0;
  endtask

  task automatic test_basic();
    cnt_t c;
    c = '0;
    c[0] = 6'd10; c[1] = 6'd10; c[2] = 6'd10;
    run_frame("basic", c, 1'b1);
  endtask

  task automatic test_clip();
    cnt_t c;
    c = '0;
    c[0] = 6'd30; c[1] = 6'd30; c[2] = 6'd30;
    run_frame("clip30", c, 1'b0);
    for (int i = 0; i < BQ; i++) c[i] = 6'd63;
    run_frame("all63", c, 1'b0);
  endtask

  task automatic test_random();
    cnt_t c;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < BQ; i++)
        c[i] = (n < 3) ? CW'($urandom_range(0, 8)) : CW'($urandom_range(0, 63));
      run_frame("random", c, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    rgb_t r1, r2, gr;
    cnt_t c1, c2, gc;
    int   acc1, acc2, s1, s2, f, rise1;
    drop_dly = 2;
    rise_dly = 10;
    r1 = rand_rgb();
    r2 = rand_rgb();
    for (int i = 0; i < BQ; i++) begin
      c1[i] = CW'($urandom_range(0, 63));
      c2[i] = CW'($urandom_range(0, 63));
    end
    clear_log();
    send_frame(r1, c1, acc1);
    send_frame(r2, c2, acc2);
    rise1 = done_rise_cyc;
    vectors++;
    if (acc2 <= rise1 || acc2 > rise1 + 3) begin
      miscompares++;
      $display("FAIL b2b_accept: got accept at %0d, need just after done rise at %0d", acc2, rise1);
    end
    wait_start(400, s1, gr, gc);
    wait_start(400, s2, gr, gc);
    vectors++;
    if (s2 - s1 < MP || s2 - s1 > MP + 2) begin
      miscompares++;
      $display("FAIL b2b_period: got %0d cycles, need %0d..%0d", s2 - s1, MP, MP + 2);
    end
    vectors++;
    if (gc !== model_counts(c2) || gr !== r2) begin
      miscompares++;
      $display("FAIL b2b_frame2: got counts %h, need %h", gc, model_counts(c2));
    end
    wait_idle(400, f);
    fs_exp += 2;
    check_sent("b2b");
    drop_dly = 5;
    rise_dly = 200;
  endtask

  task automatic test_refresh();
    rgb_t r, gr, exp_r;
    cnt_t c, gc, exp_c;
    int   acc, s, f;
    r = rand_rgb();
    for (int i = 0; i < BQ; i++) c[i] = CW'($urandom_range(0, 10));
    exp_c = model_counts(c);
    clear_log();
    send_frame(r, c, acc);
    wait_start(400, s, gr, gc);
    wait_idle(500, f);
    fs_exp++;
    for (int k = 1; k <= MR + 1; k++) begin
      wait_start(RC + 300, s, gr, gc);
      if (s >= 0) begin
        vectors++;
        if (f < 0 || s - f < RC || s - f > RC + 3) begin
          miscompares++;
          $display("FAIL refresh%0d_interval: got %0d idle cycles, need %0d..%0d", k, s - f, RC, RC + 3);
        end
        exp_r = (k <= MR) ? r : '0;
        vectors++;
        if (gr !== exp_r) begin
          miscompares++;
          $display("FAIL refresh%0d_rgb: got %h, need %h", k, gr, exp_r);
        end
        vectors++;
        if (gc !== exp_c) begin
          miscompares++;
          $display("FAIL refresh%0d_counts: got %h, need %h", k, gc, exp_c);
        end
      end
      wait_idle(500, f);
      fs_exp++;
      check_sent("refresh");
    end
  endtask

  task automatic test_reset_run();
    rgb_t r, gr;
    cnt_t c, gc;
    int   acc, s, f;
    for (int i = 0; i < BQ; i++) c[i] = CW'($urandom_range(1, 9));
    clear_log();
    send_frame(rand_rgb(), c, acc);
    wait_start(400, s, gr, gc);
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || drv_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_run_setup: got busy=%b done=%b, need 1 0", busy, drv_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (drv_start !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_run_ctrl: got start=%b busy=%b, need 0 0", drv_start, busy);
    end
    vectors++;
    if (drv_rgb !== '0 || frames_sent !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_run_state: got rgb=%h sent=%0d, need 0 0", drv_rgb, frames_sent);
    end
    @(negedge clk);
    rst = 1'b1;
    fs_exp = 0;
    for (int i = 0; i < BQ; i++) c[i] = CW'($urandom_range(0, 63));
    r = rand_rgb();
    clear_log();
    send_frame(r, c, acc);
    wait_start(600, s, gr, gc);
    vectors++;
    if (gc !== model_counts(c) || gr !== r) begin
      miscompares++;
      $display("FAIL rst_run_new: got counts %h, need %h", gc, model_counts(c));
    end
    wait_idle(500, f);
    fs_exp++;
    check_sent("rst_run");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, need finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_random();
    test_back_to_back();
    test_refresh();
    test_reset_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
